mmio_uart_tx: RTL and testbench

Memory-mapped UART transmitter on the cpu_top data-store path, downstream of the load/store unit and alongside u_dmem. CPU stores to TXDATA push bytes into a small FIFO. An 8N1 serializer drains the FIFO onto uart_tx, so compliance and ASM programs can emit console output instead of relying on register/memory dumps. CPU loads from STATUS return FIFO and overflow state.

---
 rtl/uart_pkg.sv | 19 +
 rtl/sync_fifo.sv | 66 ++++++
 rtl/mmio_uart_tx.sv | 170 +++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART: register offsets, STATUS
// bit positions and the serializer state encoding.
package uart_pkg;

    localparam logic [3:0] TXDATA_OFF = 4'h0;
    localparam logic [3:0] STATUS_OFF = 4'h4;

    localparam int STAT_FULL_BIT  = 0;
    localparam int STAT_EMPTY_BIT = 1;
    localparam int STAT_OVF_BIT   = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; DEPTH must be a power of two so the
// pointers wrap naturally.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) wptr_d = wptr_q + PTR_W'(1);
        if (do_pop)  rptr_d = rptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage is not reset; the count alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA stores feed a FIFO, STATUS
// reports full/empty/sticky overflow, and a serializer drains the FIFO.
module mmio_uart_tx
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
    parameter int          CLKS_PER_BIT = 868,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] bus_addr,
    input  logic        bus_we,
    input  logic [31:0] bus_wdata,
    input  logic        bus_re,
    output logic [31:0] bus_rdata,
    output logic        uart_tx,
    output logic        tx_busy
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

    logic             hit;
    logic [3:0]       off;
    logic             wr_txdata;
    logic             wr_status;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [7:0]       fifo_rdata;
    logic [CNT_W-1:0] fifo_count;
    logic             ovf_q, ovf_d;
    logic [31:0]      status_w;

    uart_state_e      state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             baud_done;
    logic             unused_bits;

    assign hit       = (bus_addr[31:4] == BASE_ADDR[31:4]);
    assign off       = bus_addr[3:0];
    assign wr_txdata = bus_we && hit && (off == TXDATA_OFF);
    assign wr_status = bus_we && hit && (off == STATUS_OFF);
    // Fullness is judged before any pop on the same edge.
    assign fifo_push = wr_txdata && !fifo_full;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst),
        .push_i  (fifo_push),
        .wdata_i (bus_wdata[7:0]),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // A clear and a new overflow on the same edge: the set wins.
    always_comb begin
        ovf_d = ovf_q;
        if (wr_status && bus_wdata[STAT_OVF_BIT]) ovf_d = 1'b0;
        if (wr_txdata && fifo_full)               ovf_d = 1'b1;
    end

    always_comb begin
        status_w                 = '0;
        status_w[STAT_FULL_BIT]  = fifo_full;
        status_w[STAT_EMPTY_BIT] = fifo_empty;
        status_w[STAT_OVF_BIT]   = ovf_q;
    end

    assign bus_rdata = (bus_re && hit && (off == STATUS_OFF)) ? status_w : '0;
    assign baud_done = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        fifo_pop = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_d  = ST_START;
                    baud_d   = '0;
                    fifo_pop = 1'b1;
                end
            end
            ST_START: begin
                if (baud_done) begin
                    state_d = ST_DATA;
                    baud_d  = '0;
                    bit_d   = '0;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            ST_DATA: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) state_d = ST_STOP;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            ST_STOP: begin
                if (baud_done) begin
                    baud_d = '0;
                    // Chain straight into the next frame when data is waiting.
                    if (!fifo_empty) begin
                        state_d  = ST_START;
                        fifo_pop = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        shift_d = shift_q;
        if (fifo_pop)
            shift_d = fifo_rdata;
        else if ((state_q == ST_DATA) && baud_done && (bit_q != 3'd7))
            shift_d = shift_q >> 1;
        case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift_d[0];
            default:  tx_d = 1'b1;
        endcase
    end

    assign uart_tx     = tx_q;
    assign tx_busy     = (state_q != ST_IDLE) || !fifo_empty;
    assign unused_bits = ^{bus_wdata[31:8], fifo_count};

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Randomized bench for mmio_uart_tx with a queue-and-timeline reference model.
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam int          CPB   = 4;
    localparam int          DEPTH = 4;
    localparam int          FRAME = 10 * CPB;
    localparam int          MAXC  = 8000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] bus_addr = '0;
    logic        bus_we = 1'b0;
    logic [31:0] bus_wdata = '0;
    logic        bus_re = 1'b0;
    logic [31:0] bus_rdata;
    logic        uart_tx;
    logic        tx_busy;

    always #5 clk = ~clk;

    mmio_uart_tx #(
        .BASE_ADDR    (BASE),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus_addr  (bus_addr),
        .bus_we    (bus_we),
        .bus_wdata (bus_wdata),
        .bus_re    (bus_re),
        .bus_rdata (bus_rdata),
        .uart_tx   (uart_tx),
        .tx_busy   (tx_busy)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: pending bytes, sticky overflow, and the expected line
    // level after every clock edge, filled in whenever a frame is launched.
    logic [7:0] q[$];
    bit         m_ovf = 1'b0;
    int         cyc = 0;
    int         free_at = 0;
    int         last_pop = 0;
    bit         exp_line [MAXC];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s    = '0;
        s[0] = (q.size() == DEPTH);
        s[1] = (q.size() == 0);
        s[2] = m_ovf;
        return s;
    endfunction

    function automatic bit m_busy();
        return (cyc < free_at) || (q.size() > 0);
    endfunction

    task automatic model_edge();
        bit         hit;
        bit         wr_tx;
        bit         wr_st;
        bit         full_before;
        logic [7:0] b;
        hit         = (bus_addr[31:4] == BASE[31:4]);
        wr_tx       = bus_we && hit && (bus_addr[3:0] == 4'h0);
        wr_st       = bus_we && hit && (bus_addr[3:0] == 4'h4);
        full_before = (q.size() == DEPTH);
        if ((cyc >= free_at) && (q.size() > 0)) begin
            b        = q.pop_front();
            last_pop = cyc;
            free_at  = cyc + FRAME;
            for (int j = 0; j < FRAME; j++) begin
                if (cyc + j < MAXC) begin
                    if (j < CPB)           exp_line[cyc + j] = 1'b0;
                    else if (j >= 9 * CPB) exp_line[cyc + j] = 1'b1;
                    else                   exp_line[cyc + j] = b[(j / CPB) - 1];
                end
            end
        end
        if (wr_st && bus_wdata[2]) m_ovf = 1'b0;
        if (wr_tx) begin
            if (full_before) m_ovf = 1'b1;
            else             q.push_back(bus_wdata[7:0]);
        end
    endtask

    task automatic check_outputs();
        logic [31:0] exp_rd;
        exp_rd = (bus_re && (bus_addr[31:4] == BASE[31:4]) && (bus_addr[3:0] == 4'h4))
                 ? m_status() : 32'h0;
        chk("uart_tx", 32'(uart_tx), 32'(exp_line[cyc]));
        chk("tx_busy", 32'(tx_busy), 32'(m_busy()));
        chk("rdata", bus_rdata, exp_rd);
    endtask

    task automatic bus_cycle(input bit we, input bit re, input logic [31:0] a, input logic [31:0] d);
        bus_we    = we;
        bus_re    = re;
        bus_addr  = a;
        bus_wdata = d;
        @(posedge clk);
        cyc++;
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) bus_cycle(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (m_busy() && (n < budget)) begin
            bus_cycle(1'b0, 1'b0, 32'h0, 32'h0);
            n++;
        end
        chk("drain_timeout", 32'(n < budget), 32'h1);
    endtask

    initial begin
        logic [31:0] addrs [6];
        int          rate;
        int          r;
        int          k;
        addrs[0] = BASE;
        addrs[1] = BASE + 32'h4;
        addrs[2] = BASE + 32'h8;
        addrs[3] = BASE + 32'hC;
        addrs[4] = BASE + 32'h10;
        addrs[5] = BASE + 32'h14;
        for (int i = 0; i < MAXC; i++) exp_line[i] = 1'b1;

        // Reset state
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_uart_tx", 32'(uart_tx), 32'h1);
        chk("rst_tx_busy", 32'(tx_busy), 32'h0);
        rst = 1'b1;
        bus_cycle(1'b0, 1'b1, BASE + 32'h4, 32'h0);
        chk("rst_status", bus_rdata, 32'h2);

        // Single byte 0x55 with latency check
        bus_cycle(1'b1, 1'b0, BASE, 32'h55);
        k = cyc;
        chk("pre_start_high", 32'(uart_tx), 32'h1);
        bus_cycle(1'b0, 1'b0, 32'h0, 32'h0);
        chk("start_bit_low", 32'(uart_tx), 32'h0);
        idle(FRAME - 1);
        chk("busy_last_cycle", 32'(tx_busy), 32'h1);
        bus_cycle(1'b0, 1'b1, BASE + 32'h4, 32'h0);
        chk("busy_dropped", 32'(tx_busy), 32'h0);
        chk("single_status", bus_rdata, 32'h2);
        chk("single_frame_len", 32'(cyc - k), 32'(FRAME + 1));

        // Overflow: six back-to-back writes, sixth dropped
        for (int i = 1; i <= 6; i++) bus_cycle(1'b1, 1'b0, BASE, 32'(i));
        bus_cycle(1'b0, 1'b1, BASE + 32'h4, 32'h0);
        chk("ovf_status", bus_rdata, 32'h5);
        drain(400);

        // W1C behaviour
        bus_cycle(1'b1, 1'b0, BASE + 32'h4, 32'h0);
        bus_cycle(1'b0, 1'b1, BASE + 32'h4, 32'h0);
        chk("w1c_zero_keeps", bus_rdata, 32'h6);
        bus_cycle(1'b1, 1'b0, BASE + 32'h4, 32'h4);
        bus_cycle(1'b0, 1'b1, BASE + 32'h4, 32'h0);
        chk("w1c_clears", bus_rdata, 32'h2);

        // Decode: reserved and out-of-window addresses
        bus_cycle(1'b1, 1'b0, BASE + 32'hC, 32'h41);
        bus_cycle(1'b1, 1'b0, BASE + 32'h10, 32'h41);
        bus_cycle(1'b0, 1'b1, BASE + 32'h8, 32'h0);
        chk("rsvd8_read", bus_rdata, 32'h0);
        bus_cycle(1'b0, 1'b1, BASE + 32'hC, 32'h0);
        chk("rsvdC_read", bus_rdata, 32'h0);
        bus_cycle(1'b0, 1'b1, BASE + 32'h14, 32'h0);
        chk("outside_read", bus_rdata, 32'h0);
        idle(8);
        chk("decode_no_frame", 32'(tx_busy), 32'h0);

        // Randomized traffic in segments of varying write intensity
        for (int seg = 0; seg < 8; seg++) begin
            rate = $urandom_range(2, 60);
            for (int i = 0; i < 100; i++) begin
                r = $urandom_range(0, 99);
                if (r < rate)
                    bus_cycle(1'b1, 1'($urandom_range(0, 1)), BASE, $urandom());
                else if (r < rate + 8)
                    bus_cycle(1'b1, 1'b1, BASE + 32'h4, $urandom());
                else if (r < rate + 14)
                    bus_cycle(1'b1, 1'b0, addrs[$urandom_range(2, 5)], $urandom());
                else if (r < rate + 40)
                    bus_cycle(1'b0, 1'b1, addrs[$urandom_range(0, 5)], 32'h0);
                else
                    bus_cycle(1'b0, 1'b0, 32'h0, 32'h0);
            end
        end
        drain(400);

        // Asynchronous reset during data bit 3 of 0xA5, with a byte queued behind
        bus_cycle(1'b1, 1'b0, BASE, 32'hA5);
        bus_cycle(1'b1, 1'b0, BASE, 32'h33);
        for (int i = 0; (i < 100) && (cyc < last_pop + 17); i++) bus_cycle(1'b0, 1'b0, 32'h0, 32'h0);
        chk("bit3_low_before_rst", 32'(uart_tx), 32'h0);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_async_tx", 32'(uart_tx), 32'h1);
        chk("rst_async_busy", 32'(tx_busy), 32'h0);
        q.delete();
        m_ovf   = 1'b0;
        free_at = 0;
        for (int i = cyc; i < MAXC; i++) exp_line[i] = 1'b1;
        @(negedge clk);
        cyc++;
        rst = 1'b1;
        bus_cycle(1'b0, 1'b1, BASE + 32'h4, 32'h0);
        chk("post_rst_status", bus_rdata, 32'h2);
        idle(60);
        chk("post_rst_quiet", 32'(uart_tx), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
